// File: rtl/add_pipe.sv
// add_pipe: registered adder with sum, carry-out and signed overflow, LATENCY 1 or 2.
// Define ADD_PIPE_SAT_EN to saturate s to all ones on unsigned carry-out.
module add_pipe #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int H = WIDTH / 2;

    logic [WIDTH:0]   full;
    logic             full_ovf;
    logic             full_v;
    logic [WIDTH-1:0] s_next;

    generate
        if (LATENCY == 1) begin : g_l1
            assign full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            assign full_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
            assign full_v   = in_valid;
        end else begin : g_l2
            logic [H-1:0] lo_q, ah_q, bh_q;
            logic         c_q, v_q;
            logic [H:0]   lo_sum, hi_sum;
            assign lo_sum = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
            // operand halves load only on valid so idle X never reaches stage 2
            always_ff @(posedge clk) begin
                if (rst) begin
                    lo_q <= '0;
                    ah_q <= '0;
                    bh_q <= '0;
                    c_q  <= 1'b0;
                    v_q  <= 1'b0;
                end else begin
                    v_q <= in_valid;
                    if (in_valid) begin
                        lo_q <= lo_sum[H-1:0];
                        c_q  <= lo_sum[H];
                        ah_q <= a[WIDTH-1:H];
                        bh_q <= b[WIDTH-1:H];
                    end
                end
            end
            assign hi_sum   = {1'b0, ah_q} + {1'b0, bh_q} + {{H{1'b0}}, c_q};
            assign full     = {hi_sum, lo_q};
            assign full_ovf = (ah_q[H-1] == bh_q[H-1]) && (hi_sum[H-1] != ah_q[H-1]);
            assign full_v   = v_q;
        end
    endgenerate

`ifdef ADD_PIPE_SAT_EN
    assign s_next = full[WIDTH] ? '1 : full[WIDTH-1:0];
`else
    assign s_next = full[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= full_v;
            if (full_v) begin
                s    <= s_next;
                cout <= full[WIDTH];
                ovf  <= full_ovf;
            end
        end
    end
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: drives LATENCY=1 and LATENCY=2 instances with shared stimulus against
// a queued reference; outputs must also hold their last result while idle.
module tb_add_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       cin = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       ov1, co1, of1, ov2, co2, of2;
    logic [3:0] s1, s2;

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(4), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(ov1), .s(s1), .cout(co1), .ovf(of1)
    );
    add_pipe #(.WIDTH(4), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(ov2), .s(s2), .cout(co2), .ovf(of2)
    );

    typedef struct {
        int       due;
        logic [3:0] s;
        logic     cout;
        logic     ovf;
    } ent_t;

    ent_t q[2][$];
    ent_t h[2];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic ent_t model(int x, int y, int c, int due);
        ent_t e;
        int u;
        int sx;
        int sy;
        int sr;
        u  = x + y + c;
        sx = (x > 7) ? x - 16 : x;
        sy = (y > 7) ? y - 16 : y;
        sr = sx + sy + c;
        e.due  = due;
        e.s    = u[3:0];
        e.cout = (u > 15);
        e.ovf  = (sr > 7) || (sr < -8);
`ifdef ADD_PIPE_SAT_EN
        if (e.cout) e.s = 4'hf;
`endif
        return e;
    endfunction

    task automatic check_one(int k, logic ov, logic [3:0] so, logic co, logic of);
        logic ev;
        ev = (q[k].size() > 0) && (q[k][0].due == cyc);
        chk($sformatf("L%0d_valid", k + 1), 6'(ov), 6'(ev));
        if (ev) h[k] = q[k].pop_front();
        chk($sformatf("L%0d_s", k + 1), 6'(so), 6'(h[k].s));
        chk($sformatf("L%0d_cout", k + 1), 6'(co), 6'(h[k].cout));
        chk($sformatf("L%0d_ovf", k + 1), 6'(of), 6'(h[k].ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_one(0, ov1, s1, co1, of1);
        check_one(1, ov2, s2, co2, of2);
    endtask

    task automatic drive(logic v, int x, int y, int c);
        in_valid = v;
        a = 4'(x);
        b = 4'(y);
        cin = c[0];
        if (v && !rst) begin
            q[0].push_back(model(x, y, c, cyc + 1));
            q[1].push_back(model(x, y, c, cyc + 2));
        end
        tick();
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        cin = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_on();
        rst = 1'b1;
        q[0].delete();
        q[1].delete();
        for (int k = 0; k < 2; k++) h[k] = '{0, 4'h0, 1'b0, 1'b0};
    endtask

    initial begin
        reset_on();
        idle(2);
        drive(1, 5, 5, 0);
        rst = 1'b0;
        drive(1, 0, 0, 0);
        drive(1, 2, 3, 0);
        idle(3);
        drive(1, 9, 9, 0);
        drive(1, 15, 0, 1);
        drive(1, 7, 1, 0);
        idle(3);
        drive(1, 2, 3, 0);
        drive(1, 9, 9, 0);
        drive(1, 7, 1, 0);
        reset_on();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        idle(3);
        for (int i = 0; i < 40; i++)
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        idle(3);
        chk("drain", 6'(q[0].size() + q[1].size()), 6'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
